serial_slice_adder_ctrl: RTL and testbench

Sequencer that computes a wide OPERAND_WIDTH-bit add by time-multiplexing one SLICE_WIDTH-bit carry-select adder slice over NUM_SLICES = OPERAND_WIDTH/SLICE_WIDTH cycles, least significant slice first.
- Input side: valid/ready handshake accepting operands and carry-in.
- Output side: valid/ready handshake returning the sum and carry-out.
- Sits between a requester (ALU or test controller) and the shared slice datapath. It trades latency for area.

---
 rtl/adder_ctrl_pkg.sv | 28 ++
 rtl/RCA_2bit_slice.sv | 21 ++
 rtl/serial_slice_adder_ctrl.sv | 111 +++++++++++
 tb/tb_serial_slice_adder_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the serial slice adder controller: state encoding
// and the counter-width helper.
package adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Ceiling log2; clog2(1) == 0, so callers clamp to a minimum width of 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/RCA_2bit_slice.sv
// One ADDER_WIDTH-bit adder slice: both carry-in cases are summed in
// parallel and the incoming carry selects between them.
module RCA_2bit_slice #(
  parameter int ADDER_WIDTH = 2
) (
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iCarry,
  output logic [ADDER_WIDTH-1:0] oSum,
  output logic                   oCarry
);

  logic [ADDER_WIDTH:0] sum_c0;
  logic [ADDER_WIDTH:0] sum_c1;

  assign sum_c0 = {1'b0, iA} + {1'b0, iB};
  assign sum_c1 = {1'b0, iA} + {1'b0, iB} + {{ADDER_WIDTH{1'b0}}, 1'b1};

  assign {oCarry, oSum} = iCarry ? sum_c1 : sum_c0;

endmodule

// File: rtl/serial_slice_adder_ctrl.sv
// Wide adder built by time-multiplexing one SLICE_WIDTH-bit slice over
// NUM_SLICES cycles, least significant slice first.
module serial_slice_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int OPERAND_WIDTH = 16,
  parameter int SLICE_WIDTH   = 2
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iCarry,
  input  logic                     iValid,
  output logic                     oReady,
  output logic [OPERAND_WIDTH-1:0] oSum,
  output logic                     oCarry,
  output logic                     oValid,
  input  logic                     iReady,
  output logic                     oBusy,
  output logic [1:0]               oState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; a producer holds its payload and valid until then.
  // oReady and oValid are pure decodes of the state register.

  localparam int NUM_SLICES = OPERAND_WIDTH / SLICE_WIDTH;
  localparam int CNT_W      = (clog2(NUM_SLICES) > 1) ? clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  if ((SLICE_WIDTH < 1) || (OPERAND_WIDTH < SLICE_WIDTH) ||
      ((OPERAND_WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_width
    $error("OPERAND_WIDTH must be a positive multiple of SLICE_WIDTH");
  end

  state_t                   state;
  logic [OPERAND_WIDTH-1:0] a_reg;
  logic [OPERAND_WIDTH-1:0] b_reg;
  logic [OPERAND_WIDTH-1:0] sum_reg;
  logic                     carry_reg;
  logic [CNT_W-1:0]         cnt;

  logic [SLICE_WIDTH-1:0]   slice_sum;
  logic                     slice_carry;
  logic [OPERAND_WIDTH-1:0] sum_next;

  RCA_2bit_slice #(
    .ADDER_WIDTH (SLICE_WIDTH)
  ) u_slice (
    .iA     (a_reg[SLICE_WIDTH-1:0]),
    .iB     (b_reg[SLICE_WIDTH-1:0]),
    .iCarry (carry_reg),
    .oSum   (slice_sum),
    .oCarry (slice_carry)
  );

  // New slice enters at the MSB end; after NUM_SLICES shifts the first
  // slice computed has arrived at bit 0. Also correct when NUM_SLICES == 1.
  assign sum_next = (sum_reg >> SLICE_WIDTH) |
                    (OPERAND_WIDTH'(slice_sum) << (OPERAND_WIDTH - SLICE_WIDTH));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iValid) begin
            a_reg     <= iA;
            b_reg     <= iB;
            carry_reg <= iCarry;
            cnt       <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          a_reg     <= a_reg >> SLICE_WIDTH;
          b_reg     <= b_reg >> SLICE_WIDTH;
          sum_reg   <= sum_next;
          carry_reg <= slice_carry;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST_SLICE) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (iReady) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign oReady = (state == S_IDLE);
  assign oValid = (state == S_DONE);
  assign oBusy  = (state == S_RUN) || (state == S_DONE);
  assign oSum   = sum_reg;
  assign oCarry = carry_reg;
  assign oState = state;

endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Scoreboard bench: drivers push expected results, monitors pop and compare
// whenever a result handshake completes.
module tb_serial_slice_adder_ctrl;
  import adder_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default DUT (16/2) ----------------
  logic [15:0] a, b;
  logic        cin, valid, ready_in;
  logic        rdy, cout, vld, busy;
  logic [15:0] sum;
  logic [1:0]  state;

  serial_slice_adder_ctrl #(.OPERAND_WIDTH(16), .SLICE_WIDTH(2)) dut (
    .iClk(clk), .iRst_n(rst_n), .iA(a), .iB(b), .iCarry(cin), .iValid(valid),
    .oReady(rdy), .oSum(sum), .oCarry(cout), .oValid(vld), .iReady(ready_in),
    .oBusy(busy), .oState(state)
  );

  // ---------------- narrow DUT (8/4) ----------------
  logic [7:0] s_a, s_b, s_sum;
  logic       s_cin, s_valid, s_ready_in, s_rdy, s_cout, s_vld, s_busy;
  logic [1:0] s_state;

  serial_slice_adder_ctrl #(.OPERAND_WIDTH(8), .SLICE_WIDTH(4)) dut_s (
    .iClk(clk), .iRst_n(rst_n), .iA(s_a), .iB(s_b), .iCarry(s_cin), .iValid(s_valid),
    .oReady(s_rdy), .oSum(s_sum), .oCarry(s_cout), .oValid(s_vld), .iReady(s_ready_in),
    .oBusy(s_busy), .oState(s_state)
  );

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int          lat_q[$];
  logic [8:0]  exp_s_q[$];
  int          lat_s_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor for the default DUT.
  initial begin : monitor
    logic        prev_vld;
    logic        popped;
    logic [16:0] e;
    prev_vld = 1'b0;
    popped   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
        popped   = 1'b0;
      end else begin
        if (popped) begin
          check("valid_one_cycle", vld, 1'b0);
          check("ready_after_done", rdy, 1'b1);
          popped = 1'b0;
        end
        if (vld && !prev_vld) begin
          if (lat_q.size() == 0) fail_now("unexpected_valid");
          else check("latency", cyc, lat_q.pop_front());
        end
        if (vld && ready_in) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else begin
            e = exp_q.pop_front();
            check("sum", sum, e[15:0]);
            check("carry", cout, e[16]);
            popped = 1'b1;
          end
        end
        prev_vld = vld;
      end
    end
  end

  // Monitor for the narrow DUT.
  initial begin : monitor_s
    logic       prev_vld;
    logic [8:0] e;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_vld = 1'b0;
      else begin
        if (s_vld && !prev_vld) begin
          if (lat_s_q.size() == 0) fail_now("s_unexpected_valid");
          else check("s_latency", cyc, lat_s_q.pop_front());
        end
        if (s_vld && s_ready_in) begin
          if (exp_s_q.size() == 0) fail_now("s_unexpected_result");
          else begin
            e = exp_s_q.pop_front();
            check("s_sum", s_sum, e[7:0]);
            check("s_carry", s_cout, e[8]);
          end
        end
        prev_vld = s_vld;
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic [15:0] es, input logic ec, input logic hold,
                      output int acc);
    a = ta; b = tb; cin = tc; valid = 1'b1; acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_now("accept_timeout");
    else begin
      exp_q.push_back({ec, es});
      lat_q.push_back(acc + 8);
    end
    if (!hold) valid = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec);
    int acc;
    s_a = ta; s_b = tb; s_cin = tc; s_valid = 1'b1; acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_rdy) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_now("s_accept_timeout");
    else begin
      exp_s_q.push_back({ec, es});
      lat_s_q.push_back(acc + 2);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() > 0 || exp_s_q.size() > 0); i++)
      @(posedge clk);
    if (exp_q.size() > 0 || exp_s_q.size() > 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int          acc;
    int          prev_acc;
    int          rel;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] model;

    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; valid = 1'b0; ready_in = 1'b1;
    s_a = '0; s_b = '0; s_cin = 1'b0; s_valid = 1'b0; s_ready_in = 1'b1;

    @(posedge clk);
    #1;
    check("rst_ready", rdy, 1'b1);
    check("rst_valid", vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_carry", cout, 1'b0);
    check("rst_state", state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add; operands changed while valid stays high during RUN are ignored.
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1, acc);
    a = 16'hDEAD; b = 16'hBEEF;
    @(negedge clk);
    check("busy_in_run", busy, 1'b1);
    check("ready_in_run", rdy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    valid = 1'b0;
    drain();

    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, acc);
    drain();

    // Backpressure in DONE with a pending request.
    ready_in = 1'b0;
    send(16'h0A0A, 16'h0505, 1'b0, 16'h0F0F, 1'b0, 1'b0, acc);
    for (int i = 0; i < 50 && !vld; i++) @(negedge clk);
    @(posedge clk);
    #1;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum_hold", sum, 16'h0F0F);
      check("bp_carry_hold", cout, 1'b0);
      check("bp_ready_low", rdy, 1'b0);
      check("bp_valid_high", vld, 1'b1);
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    rel = cyc;
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, acc);
    check("bp_accept_after_idle", acc, rel + 2);
    drain();

    // Asynchronous reset while the counter sits at 3.
    send(16'h4444, 16'h0000, 1'b0, 16'h4444, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    check("arst_ready", rdy, 1'b1);
    check("arst_valid", vld, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_sum", sum, 16'h0000);
    check("arst_carry", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, acc);
    drain();

    // Narrow instance: two slices per add.
    send_s(8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1);
    send_s(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0);
    drain();

    // Back-to-back with valid held high and the consumer always ready.
    ready_in = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      send(ra, rb, rc, model[15:0], model[16], 1'b1, acc);
      if (prev_acc >= 0) check("issue_interval", acc - prev_acc, 10);
      prev_acc = acc;
    end
    valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
